// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero returns an all-ones quotient, the dividend as remainder, and raises div_by_zero.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The partial remainder is always below the divisor after a restore, so its
    // top bit is zero and only WIDTH bits are stored. The shifted-out MSB is the
    // carry that forces a subtract.
    logic             rem_carry;
    logic [WIDTH-1:0] rem_low;
    logic             fits;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             accept;

    always_comb begin
        rem_carry = rem_q[WIDTH-1];
        rem_low   = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        fits      = rem_carry | (rem_low >= dvsr_q);
        rem_nx    = fits ? (rem_low - dvsr_q) : rem_low;
        quo_nx    = {quo_q[WIDTH-2:0], fits};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dbz_d   = dbz_q;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                end
            end
            S_CALC: begin
                if (dvsr_q == '0) begin
                    // Q still holds the untouched dividend here.
                    q_out_d = '1;
                    r_out_d = quo_q;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        q_out_d = quo_nx;
                        r_out_d = rem_nx;
                        dbz_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    accept = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dividend;
            dvsr_d  = divisor;
        end

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = q_out_q;
    assign remainder   = r_out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus exhaustive WIDTH=4 and random WIDTH=8 runs,
// checked against plain / and % arithmetic.
module tb_seq_divider;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, z4;
    logic [3:0] q4, r4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, z8;
    logic [7:0] q8, r8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] o_q(input int w);
        return (w == 4) ? 32'(q4) : 32'(q8);
    endfunction
    function automatic logic [31:0] o_r(input int w);
        return (w == 4) ? 32'(r4) : 32'(r8);
    endfunction
    function automatic logic [31:0] o_z(input int w);
        return (w == 4) ? 32'(z4) : 32'(z8);
    endfunction
    function automatic logic [31:0] o_busy(input int w);
        return (w == 4) ? 32'(busy4) : 32'(busy8);
    endfunction
    function automatic logic [31:0] o_done(input int w);
        return (w == 4) ? 32'(done4) : 32'(done8);
    endfunction

    task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (w == 4) begin
            start4 = s; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            start8 = s; a8 = a; b8 = b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge, then scramble them to catch re-sampling.
    task automatic launch(input int w, input logic [7:0] a, input logic [7:0] b, input string tag);
        drive(w, 1'b1, a, b);
        step();
        drive(w, 1'b0, 8'($urandom), 8'($urandom));
        chk({tag, "_acc_busy"}, o_busy(w), 32'd1);
    endtask

    task automatic wait_done(input int w, input int exp_lat, input string tag);
        int   lat = 0;
        logic busy_ok = 1'b1;
        while (o_done(w) == 32'd0 && lat < 40) begin
            if (o_busy(w) != 32'd1) busy_ok = 1'b0;
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_hi"}, 32'(busy_ok), 32'd1);
        chk({tag, "_busy_done"}, o_busy(w), 32'd0);
    endtask

    task automatic check_res(input int w, input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [31:0] ea, eb, eq, er, ez;
        ea = 32'(a);
        eb = 32'(b);
        if (eb == 0) begin
            eq = (w == 4) ? 32'hF : 32'hFF;
            er = ea;
            ez = 32'd1;
        end else begin
            eq = ea / eb;
            er = ea % eb;
            ez = 32'd0;
        end
        chk({tag, "_q"}, o_q(w), eq);
        chk({tag, "_r"}, o_r(w), er);
        chk({tag, "_dbz"}, o_z(w), ez);
        if (eb != 0) begin
            chk({tag, "_inv"}, o_q(w) * eb + o_r(w), ea);
            chk({tag, "_rlt"}, 32'(o_r(w) < eb), 32'd1);
        end
    endtask

    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input string tag);
        launch(w, a, b, tag);
        wait_done(w, (b == 0) ? 1 : w, tag);
        check_res(w, a, b, tag);
        step();
        chk({tag, "_pulse"}, o_done(w), 32'd0);
        chk({tag, "_held_q"}, o_q(w), (b == 0) ? ((w == 4) ? 32'hF : 32'hFF) : 32'(a) / 32'(b));
    endtask

    initial begin
        logic rst_done_seen;

        // reset state
        rst_n = 1'b0;
        repeat (3) step();
        for (int w = 4; w <= 8; w += 4) begin
            chk("rst_busy", o_busy(w), 32'd0);
            chk("rst_done", o_done(w), 32'd0);
            chk("rst_q", o_q(w), 32'd0);
            chk("rst_r", o_r(w), 32'd0);
            chk("rst_dbz", o_z(w), 32'd0);
        end
        rst_n = 1'b1;
        step();

        // basic cases
        run_op(4, 8'd13, 8'd3, "t1_13div3");
        run_op(4, 8'd15, 8'd1, "t2_15div1");
        run_op(4, 8'd3, 8'd9, "t2_3div9");
        run_op(4, 8'd0, 8'd5, "t2_0div5");

        // divide-by-zero and its clearing
        run_op(4, 8'd7, 8'd0, "t3_7div0");
        run_op(4, 8'd8, 8'd2, "t3_8div2");

        // start while busy is ignored; start held in DONE is accepted
        launch(4, 8'd12, 8'd5, "t4a");
        step();
        drive(4, 1'b1, 8'd9, 8'd3);
        step();
        drive(4, 1'b0, 8'd0, 8'd0);
        chk("t4_ign_busy", o_busy(4), 32'd1);
        wait_done(4, 2, "t4a");
        check_res(4, 8'd12, 8'd5, "t4a");
        drive(4, 1'b1, 8'd9, 8'd3);
        step();
        drive(4, 1'b0, 8'd0, 8'd0);
        chk("t4b_b2b_done", o_done(4), 32'd0);
        chk("t4b_b2b_busy", o_busy(4), 32'd1);
        wait_done(4, 4, "t4b");
        check_res(4, 8'd9, 8'd3, "t4b");
        step();
        chk("t4b_pulse", o_done(4), 32'd0);

        // asynchronous reset mid-operation
        launch(4, 8'd14, 8'd3, "t5");
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", o_busy(4), 32'd0);
        chk("t5_rst_done", o_done(4), 32'd0);
        chk("t5_rst_q", o_q(4), 32'd0);
        chk("t5_rst_r", o_r(4), 32'd0);
        chk("t5_rst_dbz", o_z(4), 32'd0);
        rst_done_seen = 1'b0;
        repeat (6) begin
            step();
            if (o_done(4) != 32'd0) rst_done_seen = 1'b1;
        end
        rst_n = 1'b1;
        step();
        if (o_done(4) != 32'd0) rst_done_seen = 1'b1;
        chk("t5_no_done", 32'(rst_done_seen), 32'd0);
        run_op(4, 8'd14, 8'd3, "t5_after");

        // exhaustive at WIDTH=4
        for (int i = 0; i < 256; i++) begin
            run_op(4, 8'(i % 16), 8'(i / 16), "ex4");
        end

        // random at WIDTH=8, with some zero divisors and small divisors mixed in
        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 8'd0;
                1, 2:    rb = 8'($urandom_range(1, 7));
                default: rb = 8'($urandom);
            endcase
            run_op(8, ra, rb, "rnd8");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
